cycle_sequencer: RTL
====================

CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath word width; opcode input is [WIDTH-26:0] (7 bits).
REQ-002 SHALL have parameter WAIT_MAX, default 15, maximum memory-wait cycles before fault.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port opcode  input  7  instruction bits [6:0] from IR.
REQ-006 SHALL have port IM_ack  input  1  instruction memory data valid.
REQ-007 SHALL have port DM_ack  input  1  data memory access complete.
REQ-008 SHALL have port branch_taken  input  1  ALU compare result for branches.
REQ-009 SHALL have port IM_req  output  1  instruction fetch request.
REQ-010 SHALL have port IR_load_en  output  1  IR capture strobe.
REQ-011 SHALL have port PC_write_en  output  1  PC update strobe.
REQ-012 SHALL have port PC_MUX_sel  output  1  0 = PC+4, 1 = branch/jump target.
REQ-013 SHALL have ports DM_read_en and DM_write_en  output  1 each  data memory strobes.
REQ-014 SHALL have port reg_write_en  output  1  register file write strobe.
REQ-015 SHALL have port write_MUX_sel  output  2  00 ALU, 01 DM, 10 PC+4.
REQ-016 SHALL have ports port_A_sel (0 rs1, 1 PC), port_B_sel (0 rs2, 1 imm), imm_en  output  1 each.
REQ-017 SHALL have ports state  output  3  current state code; fault  output  1  sticky fault flag.

Function
REQ-018 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5; codes 6-7 unreachable, and if entered SHALL go to FAULT.
REQ-019 FETCH: IM_req=1; on IM_ack, IR_load_en=1 for that cycle and next state DECODE.
REQ-020 DECODE: opcode latched into internal register; legal opcodes -> EXEC; any other opcode (incl. SYSTEM 1110011) -> FAULT.
REQ-021 Legal opcodes: R 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, FENCE 0001111.
REQ-022 EXEC: LOAD/STORE -> MEM; BRANCH -> PC_write_en=1, PC_MUX_sel=branch_taken, -> FETCH; FENCE -> PC_write_en=1, PC_MUX_sel=0, -> FETCH; others -> WB.
REQ-023 MEM: DM_read_en (LOAD) or DM_write_en (STORE) held high until DM_ack; on ack LOAD -> WB, STORE -> PC_write_en=1, PC_MUX_sel=0, -> FETCH.
REQ-024 WB: reg_write_en=1, PC_write_en=1, one cycle; write_MUX_sel=01 for LOAD, 10 for JAL/JALR, else 00; PC_MUX_sel=1 for JAL/JALR, else 0; -> FETCH.
REQ-025 port_A_sel=1 for AUIPC, JAL; port_B_sel=1 for all except R and BRANCH; imm_en=1 for all except R; these SHALL be driven from the latched opcode in EXEC, MEM, WB, and be 0 in FETCH, DECODE, FAULT.
REQ-026 Wait counter: cleared on every state entry, increments each FETCH/MEM cycle without ack; reaching WAIT_MAX with no ack -> FAULT; ack on the WAIT_MAX-th cycle SHALL win.
REQ-027 FAULT: all strobes and selects 0, fault=1, remains until reset.
REQ-028 Every strobe output SHALL be asserted only in the state listed; each PC_write_en and reg_write_en SHALL occur exactly once per instruction.
REQ-029 Latencies without waits: BRANCH/FENCE 3 cycles, ALU/jump 4, STORE 4, LOAD 5.

Reset
REQ-030 When rst=0 at a clock edge: state=FETCH, wait counter=0, latched opcode=0, fault=0; all outputs 0 except IM_req, which SHALL assert the first cycle after reset release.
REQ-031 Reset mid-instruction (any state, incl. MEM with strobe high) SHALL abort immediately; no further strobe for the aborted instruction.

Structure
REQ-032 State codes, opcode constants and write_MUX_sel encodings SHALL reside in shared package rv32i_pkg.
REQ-033 Opcode classification SHALL be a combinational sub-module opcode_decode, instantiated once.

Verification
REQ-034 OP-IMM 0010011, IM_ack on first FETCH cycle -> states 0,1,2,4,0; reg_write_en and PC_write_en high only in WB, write_MUX_sel=00.
REQ-035 LOAD, DM_ack after 3 wait cycles -> DM_read_en high 4 cycles, then WB with write_MUX_sel=01.
REQ-036 BRANCH with branch_taken=1 -> PC_write_en=1, PC_MUX_sel=1 in EXEC, reg_write_en never high.
REQ-037 IM_ack held low 15 cycles -> FAULT, fault=1, all strobes 0 until rst=0.
REQ-038 Opcode 1110011 -> FAULT from DECODE; rst=0 during MEM of a STORE -> DM_write_en low next cycle, state=FETCH.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared state codes, opcode constants, write-back mux encodings and the opcode class record.
// Pure declarations: no logic, no latency.
package rv32i_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_FAULT  = 3'd5;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [1:0] WSEL_ALU = 2'b00;
    localparam logic [1:0] WSEL_DM  = 2'b01;
    localparam logic [1:0] WSEL_PC4 = 2'b10;

    typedef struct packed {
        logic legal;
        logic is_load;
        logic is_store;
        logic is_branch;
        logic is_fence;
        logic is_jump;
        logic a_pc;
        logic b_imm;
        logic imm_en;
    } op_class_t;

endpackage

// File: rtl/opcode_decode.sv
// Classifies a 7-bit RV32I major opcode into control attributes.
// Latency: combinational; backpressure: none.
module opcode_decode
    import rv32i_pkg::*;
(
    input  logic [6:0] opc,
    output op_class_t  cls
);

    always_comb begin
        cls = '0;
        case (opc)
            OPC_R, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
            OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_FENCE: cls.legal = 1'b1;
            default:                                         cls.legal = 1'b0;
        endcase
        cls.is_load   = (opc == OPC_LOAD);
        cls.is_store  = (opc == OPC_STORE);
        cls.is_branch = (opc == OPC_BRANCH);
        cls.is_fence  = (opc == OPC_FENCE);
        cls.is_jump   = (opc == OPC_JAL) || (opc == OPC_JALR);
        cls.a_pc      = (opc == OPC_AUIPC) || (opc == OPC_JAL);
        cls.b_imm     = cls.legal && (opc != OPC_R) && (opc != OPC_BRANCH);
        cls.imm_en    = cls.legal && (opc != OPC_R);
    end

endmodule

// File: rtl/cycle_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky FAULT state.
// Latency: 3-5 cycles per instruction plus memory waits; stalls on IM_ack/DM_ack, faults after WAIT_MAX idle cycles.
module cycle_sequencer
    import rv32i_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-26:0] opcode,
    input  logic              IM_ack,
    input  logic              DM_ack,
    input  logic              branch_taken,
    output logic              IM_req,
    output logic              IR_load_en,
    output logic              PC_write_en,
    output logic              PC_MUX_sel,
    output logic              DM_read_en,
    output logic              DM_write_en,
    output logic              reg_write_en,
    output logic [1:0]        write_MUX_sel,
    output logic              port_A_sel,
    output logic              port_B_sel,
    output logic              imm_en,
    output logic [2:0]        state,
    output logic              fault
);

    localparam int              CW        = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0]   WAIT_LAST = CW'(WAIT_MAX - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [6:0]    opc_q, opc_d;
    logic [6:0]    dec_opc;
    logic          sel_en;
    op_class_t     cls;

    // DECODE classifies the live IR bits; later states use the latched copy.
    assign dec_opc = (state_q == ST_DECODE) ? opcode[6:0] : opc_q;

    opcode_decode u_opcode_decode (
        .opc (dec_opc),
        .cls (cls)
    );

    assign sel_en     = (state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB);
    assign port_A_sel = sel_en && cls.a_pc;
    assign port_B_sel = sel_en && cls.b_imm;
    assign imm_en     = sel_en && cls.imm_en;
    assign state      = state_q;
    assign fault      = (state_q == ST_FAULT);

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = '0;
        opc_d         = opc_q;
        IM_req        = 1'b0;
        IR_load_en    = 1'b0;
        PC_write_en   = 1'b0;
        PC_MUX_sel    = 1'b0;
        DM_read_en    = 1'b0;
        DM_write_en   = 1'b0;
        reg_write_en  = 1'b0;
        write_MUX_sel = WSEL_ALU;

        case (state_q)
            ST_FETCH: begin
                IM_req = 1'b1;
                // An ack on the last permitted cycle takes priority over the timeout.
                if (IM_ack) begin
                    IR_load_en = 1'b1;
                    state_d    = ST_DECODE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            ST_DECODE: begin
                opc_d   = opcode[6:0];
                state_d = cls.legal ? ST_EXEC : ST_FAULT;
            end
            ST_EXEC: begin
                if (cls.is_load || cls.is_store) begin
                    state_d = ST_MEM;
                end else if (cls.is_branch) begin
                    PC_write_en = 1'b1;
                    PC_MUX_sel  = branch_taken;
                    state_d     = ST_FETCH;
                end else if (cls.is_fence) begin
                    PC_write_en = 1'b1;
                    state_d     = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                DM_read_en  = cls.is_load;
                DM_write_en = cls.is_store;
                if (DM_ack) begin
                    if (cls.is_load) begin
                        state_d = ST_WB;
                    end else begin
                        PC_write_en = 1'b1;
                        state_d     = ST_FETCH;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            ST_WB: begin
                reg_write_en = 1'b1;
                PC_write_en  = 1'b1;
                PC_MUX_sel   = cls.is_jump;
                if (cls.is_load) begin
                    write_MUX_sel = WSEL_DM;
                end else if (cls.is_jump) begin
                    write_MUX_sel = WSEL_PC4;
                end else begin
                    write_MUX_sel = WSEL_ALU;
                end
                state_d = ST_FETCH;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_FETCH;
            wait_cnt_q <= '0;
            opc_q      <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            opc_q      <= opc_d;
        end
    end

endmodule
